vga_timing_gen: RTL
===================

# vga_timing_gen

Parametrised VGA raster timing generator. It replaces the fixed 640x480 counter logic inside the display module, and the divide-by-2 clock module, with a single-clock design. Its outputs are a pixel-enable strobe, registered sync signals, data-enable, pixel coordinates, and single-cycle frame/line/vblank strobes. Game and drawing logic consume these strobes on `clk` instead of clocking off `vs` edges.

## Interface
- `H_ACTIVE`, 640, visible pixels per line
- `H_FP`, 16, horizontal front porch (pixels)
- `H_SYNC`, 96, horizontal sync width (pixels)
- `H_BP`, 48, horizontal back porch (pixels)
- `V_ACTIVE`, 480, visible lines per frame
- `V_FP`, 10, vertical front porch (lines)
- `V_SYNC`, 2, vertical sync width (lines)
- `V_BP`, 33, vertical back porch (lines)
- `HS_POL`, 0, asserted level of `hs` (0 = active-low)
- `VS_POL`, 0, asserted level of `vs` (0 = active-low)
- `CLK_DIV`, 2, `clk` cycles per pixel (legal range 1..16)
- `CNT_W`, 10, coordinate width; H_TOTAL and V_TOTAL must both be ≤ 2^CNT_W
- `clk`  in  1  system clock (50 MHz on DE1-SoC)
- `rst`  in  1  synchronous, active-low reset
- `pix_en`  out  1  one-`clk` strobe per pixel period
- `hs`  out  1  horizontal sync
- `vs`  out  1  vertical sync
- `de`  out  1  high while (x,y) is inside the active area
- `x`  out  CNT_W  current horizontal count, 0..H_TOTAL-1
- `y`  out  CNT_W  current vertical count, 0..V_TOTAL-1
- `line_start`  out  1  pulse when x becomes 0
- `frame_start`  out  1  pulse when (x,y) becomes (0,0)
- `vblank_start`  out  1  pulse when (x,y) becomes (0,V_ACTIVE); this is the game-update tick

## Operation
- H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP. V_TOTAL is formed the same way from the vertical parameters. Defaults give 800 x 525.
- Divider:
  - `div` counts 0..CLK_DIV-1 every `clk`, then wraps.
  - `pix_en` is registered and is 1 in the cycle after `div` reaches CLK_DIV-1.
  - With CLK_DIV=1, `pix_en` is constantly 1 after reset.
- Counters advance only on a `clk` edge where `pix_en`=1.
  - `hcnt` wraps from H_TOTAL-1 to 0.
  - `vcnt` increments only on that wrap, and wraps from V_TOTAL-1 to 0.
- All outputs except `pix_en` are registers loaded in the same edge as the counters. They describe the new (x,y):
  - `x` = hcnt, `y` = vcnt.
  - `de` = (hcnt < H_ACTIVE) && (vcnt < V_ACTIVE).
  - `hs` is asserted (= HS_POL) for hcnt in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1], and deasserted otherwise.
  - `vs` is asserted (= VS_POL) for vcnt in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC-1], and deasserted otherwise.
  - Strobes are set for the new position and cleared on the next `clk` edge. Each strobe is therefore exactly one `clk` wide, regardless of CLK_DIV.
- Reset (`rst`=0 at a `clk` edge):
  - `div`=0.
  - Counters load (H_TOTAL-1, V_TOTAL-1).
  - `x`=0, `y`=0, `de`=0, `pix_en`=0, all strobes 0.
  - `hs`=~HS_POL, `vs`=~VS_POL.
- Reset asserted mid-frame aborts the frame immediately. No strobe may fire while `rst`=0.

## Timing
- First `pix_en` occurs CLK_DIV cycles after `rst` is released. On that edge, (x,y)=(0,0), `de`=1, and `frame_start`=`line_start`=1.
- Outputs are valid one `clk` after the `pix_en` edge that loaded them, and are held for CLK_DIV cycles.
- Frame period is H_TOTAL·V_TOTAL·CLK_DIV `clk` cycles: 840 000 at the defaults.
- At (0,V_ACTIVE), `vblank_start` and `line_start` fire together.
- At the wrap to (0,0), `frame_start` and `line_start` fire together.

## Configuration
- `VGA_FRAME_CNT_EN` defined:
  - Adds output `frame_cnt[15:0]`, which resets to 0.
  - It increments in the same edge that raises `frame_start`, excluding the first `frame_start` after reset.
  - It wraps from 0xFFFF to 0.
- `VGA_FRAME_CNT_EN` undefined: the port and its logic are absent.

## Structure
- Package `vga_pkg` holds:
  - the default 640x480@60 timing constants;
  - localparam H_TOTAL/V_TOTAL helper functions;
  - the polarity constants `SYNC_ACT_LOW`/`SYNC_ACT_HIGH`.
- Sub-module `vga_pix_div` (parameter CLK_DIV) generates `pix_en`. The top level holds the counters and output decode.

## Test plan
- Defaults, release `rst`:
  - first `pix_en` at cycle 2 with x=0, y=0, de=1, `frame_start`=1;
  - `pix_en` period is 2 `clk`.
- Defaults, one full line:
  - `hs` is low exactly while x in 656..751 (96 pixels);
  - `de` falls at x=640;
  - `line_start` fires every 1600 `clk`.
- Defaults, one full frame:
  - `vs` is low for y=490..491;
  - `vblank_start` occurs once per frame at (0,480);
  - `frame_start` is spaced 840 000 `clk` apart.
- CLK_DIV=1, 8x4 active, porches/sync 2,1,1 (H) and 1,1,1 (V), HS_POL=VS_POL=1:
  - H_TOTAL=12, V_TOTAL=7;
  - `hs` is high at x=10 only;
  - frame is 84 `clk`.
- Assert `rst` at y=200:
  - next edge gives de=0, hs=vs=1 (active-low defaults), no strobes;
  - after release, restart at (0,0) with `frame_start`.
- `VGA_FRAME_CNT_EN` defined, run 3 frames: `frame_cnt` reads 0, 1, 2 at successive `frame_start` pulses.

Source files
------------

// File: rtl/vga_pkg.sv
// vga_pkg: shared VGA timing constants, polarity values and helpers.
// Imported by vga_pix_div and vga_timing_gen.
package vga_pkg;

  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_FP     = 16;
  localparam int DEF_H_SYNC   = 96;
  localparam int DEF_H_BP     = 48;

  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FP     = 10;
  localparam int DEF_V_SYNC   = 2;
  localparam int DEF_V_BP     = 33;

  localparam logic SYNC_ACT_LOW  = 1'b0;
  localparam logic SYNC_ACT_HIGH = 1'b1;

  typedef struct packed {
    logic hs;
    logic vs;
    logic de;
  } vga_sync_t;

  function automatic int h_total(
    input int active,
    input int fp,
    input int sync,
    input int bp
  );
    return active + fp + sync + bp;
  endfunction

  function automatic int v_total(
    input int active,
    input int fp,
    input int sync,
    input int bp
  );
    return active + fp + sync + bp;
  endfunction

  // Width of a counter spanning 0..n-1 (at least one bit).
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // True when v lies in [beg, beg+len-1].
  function automatic logic in_win(
    input int v,
    input int beg,
    input int len
  );
    return (v >= beg) && (v < beg + len);
  endfunction

endpackage

// File: rtl/vga_pix_div.sv
// vga_pix_div: clk divider producing a registered one-clk pix_en strobe.
// Ports: clk, rst (sync, active-low) in; pix_en out.
module vga_pix_div
  import vga_pkg::*;
#(
  parameter int CLK_DIV = 2
) (
  input  logic clk,
  input  logic rst,
  output logic pix_en
);

  localparam int DW = cnt_width(CLK_DIV);
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);

  logic [DW-1:0] div;
  logic          div_last;

  assign div_last = (div == DIV_LAST);

  // With CLK_DIV=1 div stays 0 and div_last is always true,
  // so pix_en sits high from the first edge after reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      div    <= '0;
      pix_en <= 1'b0;
    end else begin
      pix_en <= div_last;
      if (div_last)
        div <= '0;
      else
        div <= div + DW'(1);
    end
  end

endmodule

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: single-clock VGA raster timing generator.
// Ports: clk, rst (sync, active-low) in; pix_en, hs, vs, de, x, y,
//   line_start, frame_start, vblank_start out.
// Option: define VGA_FRAME_CNT_EN to add output frame_cnt[15:0].
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int   H_ACTIVE = DEF_H_ACTIVE,
  parameter int   H_FP     = DEF_H_FP,
  parameter int   H_SYNC   = DEF_H_SYNC,
  parameter int   H_BP     = DEF_H_BP,
  parameter int   V_ACTIVE = DEF_V_ACTIVE,
  parameter int   V_FP     = DEF_V_FP,
  parameter int   V_SYNC   = DEF_V_SYNC,
  parameter int   V_BP     = DEF_V_BP,
  parameter logic HS_POL   = SYNC_ACT_LOW,
  parameter logic VS_POL   = SYNC_ACT_LOW,
  parameter int   CLK_DIV  = 2,
  parameter int   CNT_W    = 10
) (
  input  logic             clk,
  input  logic             rst,
  output logic             pix_en,
  output logic             hs,
  output logic             vs,
  output logic             de,
  output logic [CNT_W-1:0] x,
  output logic [CNT_W-1:0] y,
  output logic             line_start,
  output logic             frame_start,
`ifdef VGA_FRAME_CNT_EN
  output logic             vblank_start,
  output logic [15:0]      frame_cnt
`else
  output logic             vblank_start
`endif
);

  localparam int H_TOTAL =
    h_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int V_TOTAL =
    v_total(V_ACTIVE, V_FP, V_SYNC, V_BP);

  localparam logic [CNT_W-1:0] H_LAST =
    CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST =
    CNT_W'(V_TOTAL - 1);

  localparam int HS_BEG = H_ACTIVE + H_FP;
  localparam int VS_BEG = V_ACTIVE + V_FP;

  logic [CNT_W-1:0] hcnt;
  logic [CNT_W-1:0] vcnt;
  logic [CNT_W-1:0] h_nxt;
  logic [CNT_W-1:0] v_nxt;
  logic             h_wrap;
  logic             at_line;
  logic             at_origin;
  logic             at_vblank;
  vga_sync_t        sync_nxt;

  vga_pix_div #(
    .CLK_DIV (CLK_DIV)
  ) u_div (
    .clk    (clk),
    .rst    (rst),
    .pix_en (pix_en)
  );

  // Position the counters move to on the next pixel edge.
  always_comb begin
    h_wrap = (hcnt == H_LAST);
    h_nxt  = h_wrap ? '0 : hcnt + CNT_W'(1);
    v_nxt  = vcnt;
    if (h_wrap)
      v_nxt = (vcnt == V_LAST) ? '0 : vcnt + CNT_W'(1);
  end

  // Outputs are decoded from the new position so that the
  // registers describe (x,y) in the same edge that loads them.
  always_comb begin
    at_line   = (h_nxt == '0);
    at_origin = at_line && (v_nxt == '0);
    at_vblank = at_line && (int'(v_nxt) == V_ACTIVE);

    sync_nxt.de = (int'(h_nxt) < H_ACTIVE) &&
                  (int'(v_nxt) < V_ACTIVE);
    sync_nxt.hs = in_win(int'(h_nxt), HS_BEG, H_SYNC) ?
                  HS_POL : ~HS_POL;
    sync_nxt.vs = in_win(int'(v_nxt), VS_BEG, V_SYNC) ?
                  VS_POL : ~VS_POL;
  end

  // Counters reset to the last position so the first pixel
  // edge after reset lands on (0,0) and raises frame_start.
  always_ff @(posedge clk) begin
    if (!rst) begin
      hcnt         <= H_LAST;
      vcnt         <= V_LAST;
      x            <= '0;
      y            <= '0;
      de           <= 1'b0;
      hs           <= ~HS_POL;
      vs           <= ~VS_POL;
      line_start   <= 1'b0;
      frame_start  <= 1'b0;
      vblank_start <= 1'b0;
    end else begin
      line_start   <= 1'b0;
      frame_start  <= 1'b0;
      vblank_start <= 1'b0;
      if (pix_en) begin
        hcnt         <= h_nxt;
        vcnt         <= v_nxt;
        x            <= h_nxt;
        y            <= v_nxt;
        de           <= sync_nxt.de;
        hs           <= sync_nxt.hs;
        vs           <= sync_nxt.vs;
        line_start   <= at_line;
        frame_start  <= at_origin;
        vblank_start <= at_vblank;
      end
    end
  end

`ifdef VGA_FRAME_CNT_EN
  // The first frame after reset is frame 0, so its
  // frame_start does not advance the counter.
  logic first_frame;

  always_ff @(posedge clk) begin
    if (!rst) begin
      frame_cnt   <= '0;
      first_frame <= 1'b1;
    end else if (pix_en && at_origin) begin
      if (first_frame)
        first_frame <= 1'b0;
      else
        frame_cnt <= frame_cnt + 16'd1;
    end
  end
`endif

endmodule
